product_accumulator: RTL



---
 rtl/product_accumulator.sv | 91 +++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums the 16-bit products of one frame into a
// saturating accumulator and holds the result until the consumer accepts it.
module product_accumulator #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned MAX_TERMS = 16,
  localparam int unsigned CW = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CW-1:0]        out_count,
  output logic                 out_overflow
);

  localparam int unsigned SW = ACC_WIDTH + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [SW-1:0]        sum_ext;
  logic [CW-1:0]        count_inc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: the extra sum bit is the carry out that signals saturation
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    sum_ext   = {1'b0, acc_q} + SW'(in_product);
    count_inc = count_q + CW'(1);
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (sum_ext[ACC_WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
          end
          count_d = count_inc;
          if (in_last || (count_inc == CW'(MAX_TERMS))) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == DONE);
  assign out_sum      = acc_q;
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

endmodule
